// File: rtl/fetch_pkg.sv
// Shared definitions for the prefetching fetch stage: default geometry,
// reset PC, sequential step and the queue entry layout.
package fetch_pkg;

  localparam int FETCH_N     = 64;
  localparam int FETCH_IW    = 32;
  localparam int FETCH_DEPTH = 4;

  localparam logic [63:0] RESET_PC = 64'd0;
  localparam logic [63:0] PC_STEP  = 64'd4;

  typedef struct packed {
    logic [FETCH_N-1:0]  pc;
    logic [FETCH_IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic DEPTH x W register FIFO with push/pop/flush and occupancy count.
// Flush empties the queue by snapping the read pointer onto the write pointer.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  // Storage array; cleared on reset so the head reads zero while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; flush overrides any concurrent push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage with a prefetch queue: issues one sequential address per cycle,
// buffers {pc, instr} pairs for decode, and flushes on a taken branch.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int          N        = FETCH_N,
  parameter int          IW       = FETCH_IW,
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [N-1:0] RESET_PC = N'(fetch_pkg::RESET_PC),
  parameter logic [N-1:0] PC_STEP  = N'(fetch_pkg::PC_STEP)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PCSrc_F,
  input  logic [N-1:0]           PCBranch_F,
  output logic [N-1:0]           imem_addr_F,
  input  logic [IW-1:0]          imem_data_F,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [IW-1:0]          dec_instr,
  output logic [N-1:0]           dec_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]    pc_r;
  logic            pop_s;
  logic            push_s;
  logic [CW-1:0]   count_s;
  logic [N+IW-1:0] wdata_s;
  logic [N+IW-1:0] rdata_s;

  assign pop_s  = dec_valid & dec_ready;
  // A full queue still takes a fetch when decode frees the head this cycle
  assign push_s = !PCSrc_F && ((count_s != CW'(DEPTH)) || pop_s);

  // PC register: redirect beats sequential advance; holds while the queue is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else if (PCSrc_F) begin
      pc_r <= PCBranch_F;
    end else if (push_s) begin
      pc_r <= pc_r + PC_STEP;
    end
  end

  assign wdata_s = {pc_r, imem_data_F};

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (N + IW)
  ) u_queue (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (PCSrc_F),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s)
  );

  assign imem_addr_F = pc_r;
  assign dec_valid   = (count_s != CW'(0));
  assign dec_pc      = rdata_s[N+IW-1:IW];
  assign dec_instr   = rdata_s[IW-1:0];
  assign q_count     = count_s;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: default 64-bit/DEPTH=4 instance plus
// 32-bit DEPTH=2 and DEPTH=8 instances for the threshold and wrap sweep.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcsrc;
  logic [63:0] pcbranch;
  logic [63:0] addr;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [2:0]  qc;

  logic        pcsrc_s;
  logic [31:0] pcbranch_s;
  logic        ready_s;
  logic [31:0] addr2, data2, instr2, pc2;
  logic        valid2;
  logic [1:0]  qc2;
  logic [31:0] addr8, data8, instr8, pc8;
  logic        valid8;
  logic [3:0]  qc8;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign data  = 32'hAAAA0000 | addr[31:0];
  assign data2 = 32'hAAAA0000 | addr2;
  assign data8 = 32'hAAAA0000 | addr8;

  fetch_prefetch dut (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(pcbranch),
    .imem_addr_F(addr), .imem_data_F(data), .dec_valid(valid),
    .dec_ready(ready), .dec_instr(instr), .dec_pc(pc), .q_count(qc)
  );

  fetch_prefetch #(.N(32), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc_s), .PCBranch_F(pcbranch_s),
    .imem_addr_F(addr2), .imem_data_F(data2), .dec_valid(valid2),
    .dec_ready(ready_s), .dec_instr(instr2), .dec_pc(pc2), .q_count(qc2)
  );

  fetch_prefetch #(.N(32), .DEPTH(8)) dut8 (
    .clk(clk), .reset(reset), .PCSrc_F(pcsrc_s), .PCBranch_F(pcbranch_s),
    .imem_addr_F(addr8), .imem_data_F(data8), .dec_valid(valid8),
    .dec_ready(ready_s), .dec_instr(instr8), .dec_pc(pc8), .q_count(qc8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] exp_pc;
    reset = 1'b0; pcsrc = 1'b0; pcbranch = 64'd0; ready = 1'b0;
    pcsrc_s = 1'b0; pcbranch_s = 32'd0; ready_s = 1'b0;

    // Reset held for four cycles
    repeat (4) @(negedge clk);
    check("rst_addr", addr, 64'd0);
    check("rst_qc", 64'(qc), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_pc", pc, 64'd0);
    check("rst_instr", 64'(instr), 64'd0);

    // Sequential fill with decode stalled
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("fill_addr", addr, 64'(4 * i));
      check("fill_qc", 64'(qc), 64'(i));
    end
    check("fill_valid", 64'(valid), 64'd1);
    check("fill_pc", pc, 64'd0);
    check("fill_instr", 64'(instr), 64'hAAAA0000);
    tick();
    check("full_addr", addr, 64'd16);
    check("full_qc", 64'(qc), 64'd4);
    check("full_pc", pc, 64'd0);

    // Drain from full: one pop and one push per cycle
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_pc", pc, 64'(4 * i));
      check("drain_addr", addr, 64'(16 + 4 * i));
      check("drain_qc", 64'(qc), 64'd4);
      tick();
    end
    check("drain_end_pc", pc, 64'd32);

    // Build occupancy 3 behind a first redirect
    pcsrc = 1'b1; pcbranch = 64'd1000; ready = 1'b0;
    tick();
    pcsrc = 1'b0;
    check("redir0_qc", 64'(qc), 64'd0);
    check("redir0_addr", addr, 64'd1000);
    repeat (3) tick();
    check("pre_br_qc", 64'(qc), 64'd3);
    check("pre_br_pc", pc, 64'd1000);

    // Redirect to 127 with a concurrent pop: flush wins
    pcsrc = 1'b1; pcbranch = 64'd127; ready = 1'b1;
    tick();
    pcsrc = 1'b0; ready = 1'b0;
    check("br_qc", 64'(qc), 64'd0);
    check("br_valid", 64'(valid), 64'd0);
    check("br_addr", addr, 64'd127);
    tick();
    check("br_pc", pc, 64'd127);
    check("br_addr2", addr, 64'd131);
    check("br_instr", 64'(instr), 64'hAAAA007F);

    // Alternating backpressure: head stable while stalled, in-order exactly once
    exp_pc = 64'd127;
    for (int i = 0; i < 12; i++) begin
      ready = (i % 2) == 1;
      check("bp_valid", 64'(valid), 64'd1);
      check("bp_pc", pc, exp_pc);
      check("bp_instr", 64'(instr), 64'(32'hAAAA0000 | exp_pc[31:0]));
      if (ready) exp_pc = exp_pc + 64'd4;
      tick();
    end

    // PC wrap at 2^64
    pcsrc = 1'b1; pcbranch = 64'hFFFF_FFFF_FFFF_FFFC; ready = 1'b0;
    tick();
    pcsrc = 1'b0;
    check("wrap_addr", addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_qc0", 64'(qc), 64'd0);
    tick();
    check("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_addr0", addr, 64'd0);
    tick();
    check("wrap_qc2", 64'(qc), 64'd2);
    ready = 1'b1;
    tick();
    check("wrap_pc0", pc, 64'd0);
    check("wrap_instr0", 64'(instr), 64'hAAAA0000);
    check("wrap_qc_hold", 64'(qc), 64'd2);

    // Reset asserted between edges takes effect immediately
    ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_qc", 64'(qc), 64'd0);
    check("mid_rst_valid", 64'(valid), 64'd0);
    check("mid_rst_addr", addr, 64'd0);
    check("mid_rst_pc", pc, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Parameter sweep: full thresholds and pointer wrap over 3*DEPTH pushes
    ready_s = 1'b0;
    repeat (9) tick();
    check("d2_full_qc", 64'(qc2), 64'd2);
    check("d2_full_addr", 64'(addr2), 64'd8);
    check("d8_full_qc", 64'(qc8), 64'd8);
    check("d8_full_addr", 64'(addr8), 64'd32);
    ready_s = 1'b1;
    for (int i = 0; i < 24; i++) begin
      check("d2_pc", 64'(pc2), 64'(4 * i));
      check("d2_qc", 64'(qc2), 64'd2);
      check("d8_pc", 64'(pc8), 64'(4 * i));
      check("d8_qc", 64'(qc8), 64'd8);
      check("d8_instr", 64'(instr8), 64'(32'hAAAA0000 | 32'(4 * i)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
